// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target-with-memory block: FSM state encoding and
// bus-level constants for ACK/NACK and the R/W bit.
package i2c_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdataAck
   } i2c_state_t;

   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_mem_dp.sv
// Dual-port byte memory: bus port and host port, both with registered reads.
// A host write colliding with a bus write to the same address is dropped.
module i2c_mem_dp
   import i2c_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          bus_we,
   input  logic [AW-1:0] bus_addr,
   input  logic [7:0]    bus_wdata,
   output logic [7:0]    bus_rdata,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata
);

   logic [7:0] mem [DEPTH];
   logic       host_blocked;

   assign host_blocked = bus_we && (bus_addr == host_addr);

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (bus_we) begin
         mem[bus_addr] <= bus_wdata;
      end
      if (host_we && !host_blocked) begin
         mem[host_addr] <= host_wdata;
      end
      bus_rdata <= mem[bus_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         host_rdata <= '0;
      end else begin
         host_rdata <= mem[host_addr];
      end
   end

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with internal byte memory: oversampled SCL/SDA, START/STOP detection,
// pointer-addressed burst write/read with auto-increment, and a host preload port.
module i2c_target_mem
   import i2c_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned PTR_BYTES   = 1,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned AW         = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          sda_oe,
   input  logic [6:0]    dev_addr,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata,
   output logic          busy,
   output logic          wr_pulse
);

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic [SYNC_STAGES:0]   live_q;
   logic                   scl_s, sda_s, live;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   i2c_state_t    state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [7:0]    ptr_hi_q, ptr_hi_d;
   logic          pbyte_q, pbyte_d;
   logic          rw_q, rw_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic [7:0]    bus_rdata;
   logic          last_pbyte;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         live_q     <= '0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         live_q     <= {live_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];
   // Suppress edges until the synchronizer holds real pad samples after reset.
   assign live  = live_q[SYNC_STAGES];

   assign scl_rise  = live && scl_s && !scl_prev_q;
   assign scl_fall  = live && !scl_s && scl_prev_q;
   assign start_det = live && scl_s && scl_prev_q && sda_prev_q && !sda_s;
   assign stop_det  = live && scl_s && scl_prev_q && !sda_prev_q && sda_s;

   assign last_pbyte = (pbyte_q == 1'(PTR_BYTES - 1));

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      ptr_hi_d    = ptr_hi_q;
      pbyte_d     = pbyte_q;
      rw_d        = rw_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (start_det || stop_det) begin
         state_d   = start_det ? StAddr : StIdle;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            StAddr, StPtr, StWdata: begin
               if (bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            StRdata: bit_cnt_d = bit_cnt_q + 4'd1;
            StRdataAck: begin
               ptr_d = ptr_q + AW'(1);
               if (sda_s == NACK) begin
                  state_d = StIdle;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            StAddr: begin
               if (bit_cnt_q == 4'd8) begin
                  bit_cnt_d = '0;
                  if (shift_q[7:1] == dev_addr) begin
                     state_d  = StAddrAck;
                     rw_d     = shift_q[0];
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            StAddrAck: begin
               bit_cnt_d = '0;
               if (rw_q == RW_READ) begin
                  state_d  = StRdata;
                  shift_d  = bus_rdata;
                  sda_oe_d = !bus_rdata[7];
               end else begin
                  state_d  = StPtr;
                  sda_oe_d = 1'b0;
                  pbyte_d  = 1'b0;
                  ptr_hi_d = '0;
               end
            end
            StPtr: begin
               if (bit_cnt_q == 4'd8) begin
                  state_d   = StPtrAck;
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b1;
                  if (last_pbyte) begin
                     ptr_d = AW'({ptr_hi_q, shift_q});
                  end else begin
                     ptr_hi_d = shift_q;
                  end
               end
            end
            StPtrAck: begin
               sda_oe_d = 1'b0;
               if (last_pbyte) begin
                  state_d = StWdata;
               end else begin
                  state_d = StPtr;
                  pbyte_d = 1'b1;
               end
            end
            StWdata: begin
               if (bit_cnt_q == 4'd8) begin
                  state_d     = StWdataAck;
                  bit_cnt_d   = '0;
                  sda_oe_d    = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ptr_q;
                  mem_wdata_d = shift_q;
                  ptr_d       = ptr_q + AW'(1);
               end
            end
            StWdataAck: begin
               state_d  = StWdata;
               sda_oe_d = 1'b0;
            end
            StRdata: begin
               if (bit_cnt_q == 4'd8) begin
                  state_d   = StRdataAck;
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
               end else begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = !shift_q[6];
               end
            end
            StRdataAck: begin
               // Only reached after the master ACKed; stream the next byte.
               state_d   = StRdata;
               bit_cnt_d = '0;
               shift_d   = bus_rdata;
               sda_oe_d  = !bus_rdata[7];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         ptr_hi_q    <= '0;
         pbyte_q     <= 1'b0;
         rw_q        <= RW_WRITE;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         ptr_hi_q    <= ptr_hi_d;
         pbyte_q     <= pbyte_d;
         rw_q        <= rw_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   i2c_mem_dp #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk        (clk),
      .reset      (reset),
      .bus_we     (mem_we_q),
      .bus_addr   (mem_we_q ? mem_addr_q : ptr_q),
      .bus_wdata  (mem_wdata_q),
      .bus_rdata  (bus_rdata),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata)
   );

   assign sda_oe   = sda_oe_q;
   assign busy     = busy_q;
   assign wr_pulse = mem_we_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: three targets of different geometry share one bus; a
// bit-banged master issues directed transfers and a scoreboard checks responses.
module tb_i2c_target_mem;

   logic clk = 1'b0;
   logic reset;
   logic scl_m, sda_m, scl_line, sda_line;

   logic       sda_oe_a, busy_a, wr_pulse_a, host_we_a;
   logic [7:0] host_addr_a, host_wdata_a, host_rdata_a;
   logic       sda_oe_b, busy_b, wr_pulse_b, host_we_b;
   logic [3:0] host_addr_b;
   logic [7:0] host_wdata_b, host_rdata_b;
   logic       sda_oe_c, busy_c, wr_pulse_c, host_we_c;
   logic [9:0] host_addr_c;
   logic [7:0] host_wdata_c, host_rdata_c;

   always #5 clk = ~clk;

   assign scl_line = scl_m;
   assign sda_line = sda_m & ~sda_oe_a & ~sda_oe_b & ~sda_oe_c;

   i2c_target_mem u_a (
      .clk(clk), .reset(reset), .scl_in(scl_line), .sda_in(sda_line), .sda_oe(sda_oe_a),
      .dev_addr(7'h01), .host_we(host_we_a), .host_addr(host_addr_a),
      .host_wdata(host_wdata_a), .host_rdata(host_rdata_a), .busy(busy_a),
      .wr_pulse(wr_pulse_a)
   );

   i2c_target_mem #(.MEM_DEPTH(16)) u_b (
      .clk(clk), .reset(reset), .scl_in(scl_line), .sda_in(sda_line), .sda_oe(sda_oe_b),
      .dev_addr(7'h03), .host_we(host_we_b), .host_addr(host_addr_b),
      .host_wdata(host_wdata_b), .host_rdata(host_rdata_b), .busy(busy_b),
      .wr_pulse(wr_pulse_b)
   );

   i2c_target_mem #(.MEM_DEPTH(1024), .PTR_BYTES(2)) u_c (
      .clk(clk), .reset(reset), .scl_in(scl_line), .sda_in(sda_line), .sda_oe(sda_oe_c),
      .dev_addr(7'h05), .host_we(host_we_c), .host_addr(host_addr_c),
      .host_wdata(host_wdata_c), .host_rdata(host_rdata_c), .busy(busy_c),
      .wr_pulse(wr_pulse_c)
   );

   int wp_a = 0, wp_c = 0, oe_cnt = 0;
   always_ff @(posedge clk) begin
      wp_a   <= wp_a + (wr_pulse_a ? 1 : 0);
      wp_c   <= wp_c + (wr_pulse_c ? 1 : 0);
      oe_cnt <= oe_cnt + ((sda_oe_a | sda_oe_b | sda_oe_c) ? 1 : 0);
   end

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] act_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic exp_push(input string nm, input logic [15:0] v);
      exp_t e;
      e.name = nm;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic act_push(input logic [15:0] v);
      act_q.push_back(v);
   endtask

   // Monitor: pairs each presented DUT response with the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         while (act_q.size() > 0) begin
            logic [15:0] a;
            exp_t        e;
            a = act_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_output got %h required none", a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e.val) begin
                  n_bad++;
                  $display("FAIL %s got %h required %h", e.name, a, e.val);
               end
            end
         end
      end
   end

   task automatic q();
      repeat (5) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; q();
      scl_m = 1'b1; q();
      sda_m = 1'b1; q();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      b = sda_line; q();
      scl_m = 1'b0; q();
   endtask

   task automatic write_byte(input logic [7:0] v, input logic ack_exp, input string nm);
      logic a;
      exp_push(nm, {15'd0, ack_exp});
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(a);
      act_push({15'd0, a});
   endtask

   task automatic read_byte(input logic m_ack, input logic [7:0] v_exp, input string nm);
      logic [7:0] v;
      logic       b;
      exp_push(nm, {8'd0, v_exp});
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(m_ack);
      act_push({8'd0, v});
   endtask

   task automatic host_write(input int inst, input logic [15:0] addr, input logic [7:0] d);
      host_addr_a = addr[7:0]; host_addr_b = addr[3:0]; host_addr_c = addr[9:0];
      host_wdata_a = d; host_wdata_b = d; host_wdata_c = d;
      host_we_a = (inst == 0); host_we_b = (inst == 1); host_we_c = (inst == 2);
      @(negedge clk);
      host_we_a = 1'b0; host_we_b = 1'b0; host_we_c = 1'b0;
   endtask

   task automatic host_check(input int inst, input logic [15:0] addr, input logic [7:0] d,
                             input string nm);
      exp_push(nm, {8'd0, d});
      host_addr_a = addr[7:0]; host_addr_b = addr[3:0]; host_addr_c = addr[9:0];
      repeat (2) @(negedge clk);
      case (inst)
         0:       act_push({8'd0, host_rdata_a});
         1:       act_push({8'd0, host_rdata_b});
         default: act_push({8'd0, host_rdata_c});
      endcase
   endtask

   task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] ex);
      exp_push(nm, ex);
      act_push(act);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog timeout got running required finished");
      $fatal(1);
   end

   initial begin
      int  wp0, oe0, n;
      bit  hit;
      reset = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1;
      host_we_a = 1'b0; host_we_b = 1'b0; host_we_c = 1'b0;
      host_addr_a = '0; host_addr_b = '0; host_addr_c = '0;
      host_wdata_a = '0; host_wdata_b = '0; host_wdata_c = '0;
      #3 reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_sda_oe", {15'd0, sda_oe_a}, 16'd0);
      check_val("rst_busy", {15'd0, busy_a}, 16'd0);
      check_val("rst_wr_pulse", {15'd0, wr_pulse_a}, 16'd0);
      check_val("rst_host_rdata", {8'd0, host_rdata_a}, 16'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      host_write(0, 16'h01, 8'h05);
      host_write(0, 16'h10, 8'h99);
      host_write(0, 16'h20, 8'h00);
      host_write(1, 16'h01, 8'h33);

      // Pointer write, repeated START, single-byte read with NACK.
      i2c_start();
      write_byte(8'h02, 1'b0, "rd_addr_w_ack");
      write_byte(8'h01, 1'b0, "rd_ptr_ack");
      i2c_start();
      write_byte(8'h03, 1'b0, "rd_addr_r_ack");
      check_val("rd_busy", {15'd0, busy_a}, 16'd1);
      read_byte(1'b1, 8'h05, "rd_byte");
      i2c_stop();
      q();
      check_val("rd_sda_released", {15'd0, sda_oe_a}, 16'd0);
      check_val("rd_busy_after_stop", {15'd0, busy_a}, 16'd0);

      // Burst write of two bytes.
      wp0 = wp_a;
      i2c_start();
      write_byte(8'h02, 1'b0, "wr_addr_ack");
      write_byte(8'h02, 1'b0, "wr_ptr_ack");
      write_byte(8'h7F, 1'b0, "wr_d0_ack");
      write_byte(8'hA5, 1'b0, "wr_d1_ack");
      i2c_stop();
      host_check(0, 16'h02, 8'h7F, "wr_mem2");
      host_check(0, 16'h03, 8'hA5, "wr_mem3");
      check_val("wr_pulses", 16'(wp_a - wp0), 16'd2);

      // Unmatched address: nobody drives SDA.
      oe0 = oe_cnt;
      i2c_start();
      write_byte(8'h04, 1'b1, "bad_addr_nack");
      i2c_stop();
      check_val("bad_oe_cycles", 16'(oe_cnt - oe0), 16'd0);
      check_val("bad_busy", {15'd0, busy_a}, 16'd0);
      host_check(0, 16'h02, 8'h7F, "bad_mem_kept");

      // Pointer wrap on the 16-byte target.
      i2c_start();
      write_byte(8'h06, 1'b0, "wrap_addr_ack");
      write_byte(8'h0F, 1'b0, "wrap_ptr_ack");
      write_byte(8'h11, 1'b0, "wrap_d0_ack");
      write_byte(8'h22, 1'b0, "wrap_d1_ack");
      i2c_stop();
      host_check(1, 16'h0F, 8'h11, "wrap_mem15");
      host_check(1, 16'h00, 8'h22, "wrap_mem0");
      i2c_start();
      write_byte(8'h06, 1'b0, "wrap_raddr_w_ack");
      write_byte(8'h0F, 1'b0, "wrap_rptr_ack");
      i2c_start();
      write_byte(8'h07, 1'b0, "wrap_raddr_r_ack");
      read_byte(1'b0, 8'h11, "wrap_rd0");
      read_byte(1'b0, 8'h22, "wrap_rd1");
      read_byte(1'b1, 8'h33, "wrap_rd2");
      i2c_stop();

      // STOP after four data bits discards the partial byte.
      wp0 = wp_a;
      i2c_start();
      write_byte(8'h02, 1'b0, "part_addr_ack");
      write_byte(8'h10, 1'b0, "part_ptr_ack");
      write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
      i2c_stop();
      q();
      check_val("part_no_pulse", 16'(wp_a - wp0), 16'd0);
      check_val("part_busy", {15'd0, busy_a}, 16'd0);
      host_check(0, 16'h10, 8'h99, "part_mem_kept");

      // Reset while the target is driving a read bit.
      i2c_start();
      write_byte(8'h02, 1'b0, "rst_addr_w_ack");
      write_byte(8'h20, 1'b0, "rst_ptr_ack");
      i2c_start();
      write_byte(8'h03, 1'b0, "rst_addr_r_ack");
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      check_val("rst_mid_driving", {15'd0, sda_oe_a}, 16'd1);
      #2 reset = 1'b1;
      #1;
      check_val("rst_mid_sda_oe", {15'd0, sda_oe_a}, 16'd0);
      check_val("rst_mid_busy", {15'd0, busy_a}, 16'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      q();
      scl_m = 1'b0; q();
      write_byte(8'h02, 1'b1, "rst_no_start_nack");
      i2c_stop();

      // Two-byte pointer, with a host write colliding on the same address.
      wp0 = wp_c;
      hit = 1'b0;
      i2c_start();
      write_byte(8'h0A, 1'b0, "c_addr_ack");
      write_byte(8'h01, 1'b0, "c_ptr_hi_ack");
      write_byte(8'h23, 1'b0, "c_ptr_lo_ack");
      fork
         write_byte(8'h5A, 1'b0, "c_data_ack");
         begin
            n = 0;
            while (!hit && n < 400) begin
               @(negedge clk);
               n++;
               if (wr_pulse_c) hit = 1'b1;
            end
            if (hit) begin
               host_addr_c = 10'h123; host_wdata_c = 8'hEE; host_we_c = 1'b1;
               @(negedge clk);
               host_we_c = 1'b0;
            end
         end
      join
      i2c_stop();
      check_val("c_collide_seen", {15'd0, hit}, 16'd1);
      check_val("c_pulses", 16'(wp_c - wp0), 16'd1);
      host_check(2, 16'h123, 8'h5A, "c_mem123_bus_wins");

      repeat (20) @(negedge clk);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s got nothing required %h", e.name, e.val);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_target_mem.md
# i2c_target_mem

Parametrised I2C target (slave) with internal byte memory, the next generation of the I2C slave-with-memory block on the APB–I2C bus. Implements standard I2C framing: START, 7-bit device address + R/W, register-pointer byte(s), multi-byte burst write or read with pointer auto-increment, repeated START and STOP. SCL/SDA are oversampled on the system clock. A host-side port allows preload and readback without bus traffic.

## Interface
Parameters:
- MEM_DEPTH, 256, bytes of memory; power of two, 2..65536
- PTR_BYTES, 1, register-pointer bytes sent after address+W (1 or 2, MSB first); pointer = low $clog2(MEM_DEPTH) bits
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (≥2)

Ports:
- clk  in  1  system clock, ≥8× SCL rate
- reset  in  1  asynchronous, active-high
- scl_in  in  1  SCL pad input
- sda_in  in  1  SDA pad input
- sda_oe  out  1  1 = pull SDA low (open drain); pad drives 0 when set
- dev_addr  in  7  this target's address, quasi-static
- host_we  in  1  host write strobe
- host_addr  in  $clog2(MEM_DEPTH)  host address
- host_wdata  in  8  host write data
- host_rdata  out  8  memory[host_addr], registered, 1-cycle latency
- busy  out  1  1 from own-address ACK until STOP/START
- wr_pulse  out  1  1-cycle pulse per byte committed from bus

## Operation
- Synchronize SCL/SDA, detect edges. START: SDA fall while SCL high; STOP: SDA rise while SCL high. Data sampled on SCL rise, sda_oe updated on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE → ADDR on START. ADDR shifts 8 bits MSB-first. Match (bits[7:1]==dev_addr) → ADDR_ACK (drive low one SCL period); mismatch → IDLE, no drive.
- After ADDR_ACK: W → PTR (PTR_BYTES bytes, each ACKed, then WDATA); R → RDATA from current pointer.
- WDATA: byte written to memory[ptr] at its ACK SCL fall edge; wr_pulse; ptr+1 mod MEM_DEPTH; ACK always.
- RDATA: shift memory[ptr] MSB-first, drive only 0 bits; after 8th bit release SDA, sample master ACK on SCL rise: ACK (0) → ptr+1, next byte; NACK (1) → ptr+1, release SDA, wait for STOP/START (state IDLE-like, no drive).
- Pointer persists across transactions (write pointer then repeated-START read works).
- START anywhere (repeated START) → ADDR, bit counter cleared, SDA released. STOP anywhere → IDLE, SDA released, partial byte discarded.
- Simultaneous host_we and bus write to same address in same clk: bus write wins. Host reads have no effect on bus.

## Timing
- Reset: sda_oe=0, busy=0, wr_pulse=0, host_rdata=0, state IDLE, ptr=0, counters 0. Memory not reset.
- Reset mid-transaction: immediate SDA release; next bus activity ignored until a START.
- Pad-to-detect latency: SYNC_STAGES+1 clk. sda_oe changes exactly 1 clk after detected SCL fall.
- Memory write occurs 1 clk after detected SCL fall ending 8th data bit; wr_pulse same cycle.
- busy rises with ACK drive, falls 1 clk after STOP/START detect.
- Pointer wrap: MEM_DEPTH-1 → 0, no NACK.

## Structure
- Package i2c_pkg: state enum i2c_state_t, ACK=1'b0/NACK=1'b1 constants, RW_READ=1, RW_WRITE=0.
- Sub-module i2c_mem_dp: dual-port byte array (bus port write/read, host port write/read, bus-wins collision rule).
- Top holds synchronizer, edge/START/STOP detect, FSM, shifters, pointer.

## Test plan
- Preload memory[1]=8'h05 via host; START, 0x02 (addr 1,W), ptr 0x01, repeated START, 0x03, read 1 byte, NACK, STOP → byte 8'h05, three ACKs, SDA released.
- Write burst: addr 1 W, ptr 0x02, data 0x7F, 0xA5, STOP → host_rdata[2]=0x7F, [3]=0xA5, two wr_pulses.
- Wrong address 0x04 (addr 2) → no ACK, sda_oe never 1, busy=0, memory unchanged.
- Wrap: MEM_DEPTH=16, ptr 0x0F, write 0x11, 0x22 → mem[15]=0x11, mem[0]=0x22; read 3 from 0x0F with ACK,ACK,NACK → 0x11,0x22,mem[1].
- STOP after 4 data bits mid-write → no write, no wr_pulse, state IDLE; reset asserted mid-read → sda_oe=0 within same cycle, busy=0.
- PTR_BYTES=2, MEM_DEPTH=1024: ptr 0x01,0x23 then write 0x5A → mem[0x123]=0x5A; concurrent host_we same address same clk → bus value retained.
